// File: rtl/sub_round_constant_seq_pkg.sv
// Shared definitions for the round-constant adder/subtractor pair: symbol width,
// the single round-constant table and the sequencer state encoding.
package sub_round_constant_seq_pkg;

    localparam int SYM_W = 7;
    localparam int NUM_K = 12;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Entries past the end of the table all reuse the last constant.
    localparam logic [SYM_W-1:0] RC_TABLE [NUM_K] = '{
        7'h5A, 7'h34, 7'h73, 7'h66, 7'h57, 7'h35,
        7'h71, 7'h62, 7'h5F, 7'h25, 7'h51, 7'h22
    };

endpackage

// File: rtl/round_constant_rom.sv
// Combinational round-constant lookup; any index at or beyond the last entry
// returns the final table constant.
module round_constant_rom
    import sub_round_constant_seq_pkg::*;
#(
    parameter int IDX_W = 4
) (
    input  logic [IDX_W-1:0] idx,
    output logic [SYM_W-1:0] k
);

    always_comb begin
        k = RC_TABLE[NUM_K-1];
        for (int i = 0; i < NUM_K - 1; i++) begin
            if (32'(idx) == i) begin
                k = RC_TABLE[i];
            end
        end
    end

endmodule

// File: rtl/sub_round_constant_seq.sv
// Multicycle custom instruction that undoes R add-round-constant steps on a
// 7-bit symbol, subtracting one constant per enabled cycle from index R-1 down to 0.
module sub_round_constant_seq
    import sub_round_constant_seq_pkg::*;
#(
    parameter int NUM_ROUNDS = 12
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clk_en,
    input  logic        start,
    input  logic [31:0] dataa,
    input  logic [31:0] datab,
    output logic [31:0] result,
    output logic        done,
    output logic        busy,
    output logic [1:0]  dbg_state
);

    localparam int CNT_W = $clog2(NUM_ROUNDS + 1);

    // Handshake: start is sampled only on an enabled edge while idle; done is a
    // level that is high for exactly the enabled cycle spent in DONE, busy
    // covers RUN and DONE, and start seen while busy is dropped, never queued.

    state_t             state, state_nxt;
    logic [SYM_W-1:0]   acc, acc_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [CNT_W-1:0]   eff_r;
    logic [CNT_W-1:0]   rc_idx;
    logic [SYM_W-1:0]   rc_k;
    logic               unused_dataa_hi;

    assign unused_dataa_hi = ^dataa[31:SYM_W];

    // Round count saturates at NUM_ROUNDS, comparing the full unsigned word.
    assign eff_r  = (datab > 32'(NUM_ROUNDS)) ? CNT_W'(NUM_ROUNDS) : datab[CNT_W-1:0];
    assign rc_idx = cnt - CNT_W'(1);

    round_constant_rom #(
        .IDX_W (CNT_W)
    ) u_rom (
        .idx (rc_idx),
        .k   (rc_k)
    );

    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                    acc_nxt   = dataa[SYM_W-1:0];
                    cnt_nxt   = eff_r;
                end
            end
            RUN: begin
                if (cnt == '0) begin
                    state_nxt = DONE;
                end else begin
                    acc_nxt = acc - rc_k;
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
        end else if (clk_en) begin
            state <= state_nxt;
            acc   <= acc_nxt;
            cnt   <= cnt_nxt;
        end
    end

    assign done      = (state == DONE);
    assign busy      = (state != IDLE);
    assign result    = {{(32 - SYM_W){1'b0}}, acc};
    assign dbg_state = state;

endmodule

// File: tb/tb_sub_round_constant_seq.sv
// Self-checking bench for sub_round_constant_seq: directed vector table,
// multicycle corner sequences and randomized forward-add/subtract round trips.
module tb_sub_round_constant_seq;

    localparam int NR = 12;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        clk_en;
    logic        start;
    logic [31:0] dataa;
    logic [31:0] datab;
    logic [31:0] result;
    logic        done;
    logic        busy;
    logic [1:0]  dbg_state;

    int checks   = 0;
    int failures = 0;

    logic [6:0] exp_q[$];
    logic [6:0] k_ref [NR] = '{7'h5A, 7'h34, 7'h73, 7'h66, 7'h57, 7'h35,
                               7'h71, 7'h62, 7'h5F, 7'h25, 7'h51, 7'h22};

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [6:0]  exp_res;
        int          exp_lat;
    } vec_t;

    sub_round_constant_seq #(.NUM_ROUNDS(NR)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .clk_en    (clk_en),
        .start     (start),
        .dataa     (dataa),
        .datab     (datab),
        .result    (result),
        .done      (done),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic int eff_rounds(logic [31:0] r);
        if (r > 32'(NR)) return NR;
        return int'(r);
    endfunction

    function automatic logic [6:0] ref_fwd(logic [6:0] sym, logic [31:0] r);
        int s = int'(sym);
        for (int i = 0; i < eff_rounds(r); i++) s = s + int'(k_ref[i]);
        return 7'(s);
    endfunction

    // ---------------- helpers / drivers ----------------
    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(string name, logic [31:0] a, logic [31:0] b,
                          logic [6:0] exp_res, int exp_lat);
        int         lat;
        logic [31:0] junk;
        logic [6:0]  exp;
        exp_q.push_back(exp_res);
        clk_en = 1'b1;
        dataa  = a;
        datab  = b;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        junk   = $urandom;
        dataa  = junk;
        datab  = $urandom;
        check({name, " busy_after_accept"}, 32'(busy), 32'd1);
        lat = 0;
        while (!done && lat < 100) begin
            tick();
            lat++;
        end
        exp = exp_q.pop_front();
        check({name, " latency"}, 32'(lat), 32'(exp_lat));
        check({name, " result"}, result, {25'd0, exp});
        tick();
        check({name, " done_single"}, 32'(done), 32'd0);
        check({name, " idle_busy"}, 32'(busy), 32'd0);
        tick();
        check({name, " result_hold"}, result, {25'd0, exp});
    endtask

    // ---------------- stimulus ----------------
    initial begin
        vec_t        vecs [9];
        int          lat, pulses;
        logic        bad;
        logic [6:0]  res_at_done;
        logic [31:0] up;

        vecs = '{
            '{32'h0000005A, 32'd1,          7'h00, 2},
            '{32'h0000000E, 32'd2,          7'h00, 3},
            '{32'h0000003D, 32'd12,         7'h00, 13},
            '{32'h00000000, 32'd1,          7'h26, 2},
            '{32'h0000007F, 32'd0,          7'h7F, 1},
            '{32'h0000003D, 32'd15,         7'h00, 13},
            '{32'hABCDEF3D, 32'd12,         7'h00, 13},
            '{32'h0000003D, 32'hFFFFFFFF,   7'h00, 13},
            '{32'h00000026, 32'd1,          7'h4C, 2}
        };

        // reset block
        reset_n = 1'b0;
        clk_en  = 1'b1;
        start   = 1'b0;
        dataa   = '0;
        datab   = '0;
        #1;
        check("reset result", result, 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        tick();
        tick();
        reset_n = 1'b1;
        tick();

        // table-driven directed vectors
        foreach (vecs[i]) begin
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b,
                   vecs[i].exp_res, vecs[i].exp_lat);
        end

        // start re-pulsed during RUN and DONE is ignored
        dataa = 32'h3D; datab = 32'd15; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        dataa = 32'h11; datab = 32'd1; start = 1'b1;
        tick(); tick();
        start  = 1'b0;
        pulses = 0;
        res_at_done = '1;
        for (int c = 0; c < 20; c++) begin
            if (done) begin
                pulses++;
                res_at_done = result[6:0];
            end
            start = done;
            tick();
        end
        start = 1'b0;
        check("restart done_count", 32'(pulses), 32'd1);
        check("restart result", {25'd0, res_at_done}, 32'd0);
        check("restart idle_after", 32'(busy), 32'd0);

        // clk_en low for 5 cycles mid-RUN, then stretched done
        dataa = 32'h3D; datab = 32'd12; start = 1'b1;
        tick();
        start = 1'b0;
        lat = 0;
        for (int c = 0; c < 4; c++) begin tick(); lat++; end
        clk_en = 1'b0;
        bad = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick(); lat++;
            if (done || !busy) bad = 1'b1;
        end
        check("clken_hold_busy", 32'(bad), 32'd0);
        clk_en = 1'b1;
        while (!done && lat < 100) begin tick(); lat++; end
        check("clken latency", 32'(lat), 32'd18);
        check("clken result", result, 32'd0);
        clk_en = 1'b0;
        tick(); tick(); tick();
        check("clken done_stretch", 32'(done), 32'd1);
        clk_en = 1'b1;
        tick();
        check("clken done_release", 32'(done), 32'd0);

        // reset pulsed mid-RUN aborts the operation
        dataa = 32'h5A; datab = 32'd12; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        #2;
        reset_n = 1'b0;
        #1;
        check("midreset result", result, 32'd0);
        check("midreset done", 32'(done), 32'd0);
        check("midreset busy", 32'(busy), 32'd0);
        tick();
        reset_n = 1'b1;
        bad = 1'b0;
        for (int c = 0; c < 15; c++) begin
            tick();
            if (done || busy) bad = 1'b1;
        end
        check("midreset no_done", 32'(bad), 32'd0);
        run_op("post_reset", 32'h0000005A, 32'd1, 7'h00, 2);

        // randomized round trips against the forward model
        for (int n = 0; n < 40; n++) begin
            logic [6:0]  sym;
            logic [31:0] b;
            sym = 7'($urandom_range(0, 127));
            if ($urandom_range(0, 4) == 0) b = $urandom | 32'h10;
            else                           b = 32'($urandom_range(0, NR));
            up = $urandom;
            run_op($sformatf("rand%0d", n), {up[31:7], ref_fwd(sym, b)}, b,
                   sym, eff_rounds(b) + 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog: the whole run is a few thousand cycles.
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sub_round_constant_seq.md
SUB_ROUND_CONSTANT_SEQ -- requirements
Module: sub_round_constant_seq

Interface
REQ-001 The block SHALL have parameter NUM_ROUNDS, default 12, giving the maximum number of rounds undone per operation.
REQ-002 Port clk SHALL be an input, 1 bit, and is the single clock; all state updates on its rising edge.
REQ-003 Port reset_n SHALL be an input, 1 bit, and is an asynchronous active-low reset.
REQ-004 Port clk_en SHALL be an input, 1 bit; when low, all state SHALL hold (multicycle custom-instruction clock enable).
REQ-005 Port start SHALL be an input, 1 bit; it requests a new operation.
REQ-006 Port dataa SHALL be an input, 32 bits; bits [6:0] hold the symbol to decode and bits [31:7] are ignored.
REQ-007 Port datab SHALL be an input, 32 bits; its value is the round count R to undo.
REQ-008 Port result SHALL be an output, 32 bits; bits [6:0] hold the decoded symbol and bits [31:7] SHALL be 0.
REQ-009 Port done SHALL be an output, 1 bit; it pulses high for one enabled cycle when result is valid.
REQ-010 Port busy SHALL be an output, 1 bit; it is high while an operation is in progress.

Function
REQ-011 The block SHALL invert the forward add-round-constant step by subtracting, modulo 128, the constants for round indices R-1 down to 0, one per enabled cycle.
REQ-012 The constant table, indexed 0..11, SHALL be 0x5A, 0x34, 0x73, 0x66, 0x57, 0x35, 0x71, 0x62, 0x5F, 0x25, 0x51, 0x22; any index of 11 or above SHALL use 0x22.
REQ-013 The effective round count SHALL be min(datab, NUM_ROUNDS), with datab compared as an unsigned 32-bit value.
REQ-014 The state machine SHALL have three states: IDLE, RUN and DONE.
- IDLE to RUN on start with clk_en high.
- RUN to DONE when the round counter is 0.
- DONE to IDLE unconditionally on the next enabled cycle.
REQ-015 On acceptance, the block SHALL load acc = dataa[6:0] and cnt = effective R.
REQ-016 In RUN with cnt != 0, on each enabled cycle acc SHALL become (acc - K[cnt-1]) mod 128 and cnt SHALL decrement by 1.
REQ-017 done SHALL be high exactly while in DONE, which is R+1 enabled cycles after the acceptance edge; R=0 therefore gives done 1 cycle after acceptance with result = dataa[6:0].
REQ-018 busy SHALL be high in RUN and in DONE.
REQ-019 start asserted in RUN or DONE SHALL be ignored; start is not queued.
REQ-020 result SHALL equal acc and SHALL hold its last value in IDLE until the next acceptance.
REQ-021 Subtraction underflow SHALL wrap modulo 128 without any flag.
REQ-022 With clk_en low, the block SHALL hold state, acc, cnt and done; a done pulse stretches until the next enabled edge.

Reset
REQ-023 While reset_n is low, asynchronously: state = IDLE, acc = 0, cnt = 0, done = 0, busy = 0, result = 0.
REQ-024 Reset asserted during RUN SHALL abort the operation with no done pulse; the first operation after reset release SHALL behave as from power-up.

Structure
REQ-025 A shared package SHALL hold the 12-entry round-constant table, the state enum (IDLE, RUN, DONE) and the symbol width constant 7; the forward adder and this block both use this one table.
REQ-026 One sub-module, round_constant_rom (index in, 7-bit constant out, combinational), is natural and SHALL be the only sub-module.

Verification
REQ-027 The bench SHALL cover the following directed scenarios:
- dataa=0x5A, R=1 -> result 0x00, done 2 cycles after start.
- dataa=0x0E, R=2 -> result 0x00; dataa=0x3D, R=12 -> result 0x00, done 13 cycles after start.
- dataa=0x00, R=1 -> result 0x26 (wrap); dataa=0x7F, R=0 -> result 0x7F, done 1 cycle after start.
- dataa=0x3D, R=15 -> clamped to 12, result 0x00; start re-pulsed during RUN -> ignored, exactly one done.
- clk_en low for 5 cycles mid-RUN -> result and latency shifted by exactly 5 cycles; reset_n pulsed low mid-RUN -> outputs 0, no done, next op correct.
- Random dataa and R in 0..12, forward-add then sub -> original symbol recovered.
